// File: rtl/apb3_cmd_master.sv
// -----------------------------------------------------------------------------
// apb3_cmd_master
//
// APB3 initiator. It takes one command at a time from a valid/ready command
// stream, runs it as an APB3 SETUP/ACCESS transfer, and returns read data and
// status on a valid/ready response stream. Only one transfer is in flight at
// any time, so there is no internal queue.
//
// Ports:
//   clk, resetn          bus clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address and write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and timeouts)
//   rsp_error            slave error or timeout
//   rsp_timeout          transfer aborted because PREADY never rose
//   PADDR..PWDATA        APB3 request side
//   PRDATA, PREADY,
//   PSLVERROR            APB3 completion side
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module apb3_cmd_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB3
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERROR
);

  // Counter wide enough to hold TIMEOUT_CYCLES; one bit when disabled.
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Count value seen during the last permitted wait cycle of ACCESS.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      (TIMEOUT_CYCLES < 1) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_reg,     state_next;
  logic [CNT_WIDTH-1:0]  count_reg,     count_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rdata_reg,     rdata_next;
  logic                  error_reg,     error_next;
  logic                  timeout_reg,   timeout_next;
  logic [ADDR_WIDTH-1:0] paddr_reg,     paddr_next;
  logic                  psel_reg,      psel_next;
  logic                  penable_reg,   penable_next;
  logic                  pwrite_reg,    pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_reg,    pwdata_next;

  logic timeout_hit;

  // Abort only when the slave is still stalling in the last permitted cycle;
  // a PREADY in that same cycle wins and completes normally.
  assign timeout_hit = TIMEOUT_EN && (count_reg == CNT_LAST);

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    cmd_ready_next = cmd_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rdata_next     = rdata_reg;
    error_next     = error_reg;
    timeout_next   = timeout_reg;
    paddr_next     = paddr_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;

    case (state_reg)
      ST_IDLE: begin
        // cmd_ready_reg is still 0 for the first cycle after reset release,
        // so nothing is accepted until it has been advertised.
        if (cmd_valid && cmd_ready_reg) begin
          paddr_next     = cmd_addr;
          pwdata_next    = cmd_wdata;
          pwrite_next    = cmd_write;
          psel_next      = 1'b1;
          penable_next   = 1'b0;
          cmd_ready_next = 1'b0;
          state_next     = ST_SETUP;
        end else begin
          cmd_ready_next = 1'b1;
        end
      end

      ST_SETUP: begin
        penable_next = 1'b1;
        count_next   = '0;
        state_next   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          rdata_next     = pwrite_reg ? '0 : PRDATA;
          error_next     = PSLVERROR;
          timeout_next   = 1'b0;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if (timeout_hit) begin
          rdata_next     = '0;
          error_next     = 1'b1;
          timeout_next   = 1'b1;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if (TIMEOUT_EN) begin
          count_next = count_reg + CNT_WIDTH'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        rsp_valid_next = 1'b0;
        cmd_ready_next = 1'b0;
        state_next     = ST_IDLE;
      end
    endcase
  end

  // Reset drops PSEL/PENABLE/rsp_valid at once, abandoning any transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      error_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      paddr_reg     <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
      error_reg     <= error_next;
      timeout_reg   <= timeout_next;
      paddr_reg     <= paddr_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rdata_reg;
  assign rsp_error   = error_reg;
  assign rsp_timeout = timeout_reg;
  assign PADDR       = paddr_reg;
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PWDATA      = pwdata_reg;

endmodule
